flt2int_batch_ctrl: RTL and testbench

Sequencer that runs a batch of half-precision-float-to-int16 conversions over data memory using one shared multi-cycle flt2int converter. For each entry it reads two float bytes, launches the converter with a start/done handshake, and writes the two result bytes back. It sits between the byte-wide data memory port and the converter, and reports completion to the top-level start/done handshake.

---
 rtl/flt2int_batch_ctrl.sv | 151 +++++++++++++++
 tb/tb_flt2int_batch_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flt2int_batch_ctrl.sv
// Batch sequencer: converts fp16 operands in data memory to int16 results
// through a shared multi-cycle converter with a start/done handshake.
module flt2int_batch_ctrl #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned STRIDE  = 4,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [CNT_W-1:0]  conv_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              cvt_start,
  output logic [15:0]       cvt_in,
  input  logic              cvt_done,
  input  logic [15:0]       cvt_out
);

  localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_LO,
    S_RD_HI,
    S_LAUNCH,
    S_WAIT,
    S_WR_LO,
    S_WR_HI,
    S_NEXT,
    S_FIN
  } state_t;

  state_t             state;
  logic [ADDR_W-1:0]  ptr;
  logic [CNT_W-1:0]   rem;
  logic [7:0]         op_lo;
  logic [7:0]         res_hi;
  logic [TMR_W-1:0]   timer;
  logic               armed;

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      rem        <= '0;
      op_lo      <= '0;
      res_hi     <= '0;
      timer      <= '0;
      armed      <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      conv_count <= '0;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      cvt_start  <= 1'b0;
      cvt_in     <= '0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (start) begin
            ptr        <= base_in;
            rem        <= count_in;
            conv_count <= '0;
            err        <= 1'b0;
            if (count_in == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= S_RD_LO;
              done     <= 1'b0;
              busy     <= 1'b1;
              mem_addr <= base_in;
            end
          end
        end
        S_RD_LO: begin
          op_lo    <= mem_rdata;
          mem_addr <= ptr + ADDR_W'(1);
          state    <= S_RD_HI;
        end
        S_RD_HI: begin
          cvt_in    <= {mem_rdata, op_lo};
          cvt_start <= 1'b1;
          state     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          cvt_start <= 1'b0;
          armed     <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A done level still high from the previous conversion is ignored until it drops.
          if (cvt_done && armed) begin
            res_hi    <= cvt_out[15:8];
            mem_addr  <= ptr + ADDR_W'(2);
            mem_wen   <= 1'b1;
            mem_wdata <= cvt_out[7:0];
            state     <= S_WR_LO;
          end else begin
            if (!cvt_done) armed <= 1'b1;
            timer <= timer + TMR_W'(1);
            if (timer == TMR_W'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_FIN;
            end
          end
        end
        S_WR_LO: begin
          mem_addr  <= ptr + ADDR_W'(3);
          mem_wdata <= res_hi;
          state     <= S_WR_HI;
        end
        S_WR_HI: begin
          mem_wen <= 1'b0;
          state   <= S_NEXT;
        end
        S_NEXT: begin
          conv_count <= conv_count + CNT_W'(1);
          ptr        <= ptr + ADDR_W'(STRIDE);
          rem        <= rem - CNT_W'(1);
          if (rem == CNT_W'(1)) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state    <= S_RD_LO;
            mem_addr <= ptr + ADDR_W'(STRIDE);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flt2int_batch_ctrl.sv
// Scoreboard bench for flt2int_batch_ctrl with a byte memory and a latency-modelled converter.
module tb_flt2int_batch_ctrl;

  localparam int unsigned TIMEOUT = 1023;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_in;
  logic [3:0]  count_in;
  logic        done, busy, err;
  logic [3:0]  conv_count;
  logic [7:0]  mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        cvt_start;
  logic [15:0] cvt_in;
  logic        cvt_done;
  logic [15:0] cvt_out;

  logic [7:0]  mem [256];
  logic        man_en = 1'b0, man_done = 1'b0;
  logic [15:0] man_out = 16'h0;
  logic        m_done = 1'b0;
  logic [15:0] m_out = 16'h0;
  int          m_cnt = 0;

  logic [15:0] exp_wr[$], obs_wr[$], exp_cvt[$], obs_cvt[$];
  int n_cmp = 0, n_bad = 0;
  int done_cyc, st_cyc, n_st, busy_cyc;
  logic [15:0] e16, o16;

  flt2int_batch_ctrl #(.ADDR_W(8), .CNT_W(4), .STRIDE(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .base_in(base_in), .count_in(count_in),
    .done(done), .busy(busy), .err(err), .conv_count(conv_count),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cvt_start(cvt_start), .cvt_in(cvt_in), .cvt_done(cvt_done), .cvt_out(cvt_out)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign cvt_done  = man_en ? man_done : m_done;
  assign cvt_out   = man_en ? man_out  : m_out;

  function automatic logic [15:0] f2i(input logic [15:0] h);
    int e, mag;
    e = int'(h[14:10]) - 15;
    if (h[14:10] == 5'd0 || e < 0) return 16'h0000;
    if (e >= 15) return h[15] ? 16'h8000 : 16'h7FFF;
    mag = 1024 + int'(h[9:0]);
    mag = (e >= 10) ? (mag << (e - 10)) : (mag >> (10 - e));
    return h[15] ? 16'(-mag) : 16'(mag);
  endfunction

  // Converter: done rises 3 cycles after the start pulse; operand 0x7E00 never completes.
  always @(posedge clk) begin
    if (cvt_start) begin
      m_done <= 1'b0;
      m_out  <= f2i(cvt_in);
      m_cnt  <= (cvt_in == 16'h7E00) ? 0 : 2;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  // Issues one batch and records converter launches and memory writes until done or budget.
  task automatic run_batch(input logic [7:0] base, input logic [3:0] cnt, input int budget,
                           input int stop_at, input bit stale, input bit poke,
                           output int d_cyc, output int s_cyc, output int ns, output int bz);
    int cyc;
    obs_wr.delete(); obs_cvt.delete();
    d_cyc = -1; s_cyc = -1; ns = 0; bz = 0;
    start = 1'b1; base_in = base; count_in = cnt;
    @(negedge clk);
    start = 1'b0; base_in = ~base; count_in = ~cnt;
    cyc = 1;
    while (cyc <= budget) begin
      if (busy) bz++;
      if (cvt_start) begin
        ns++; s_cyc = cyc; obs_cvt.push_back(cvt_in);
        if (stop_at == ns) return;
      end
      if (mem_wen) begin
        obs_wr.push_back({mem_addr, mem_wdata});
        mem[mem_addr] = mem_wdata;
      end
      if (done) begin d_cyc = cyc; return; end
      if (stale && s_cyc >= 0) begin
        if (cyc == s_cyc + 2) man_done = 1'b0;
        if (cyc == s_cyc + 4) begin man_done = 1'b1; man_out = 16'h0005; end
      end
      if (poke) start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_in = 8'h0; count_in = 4'h0;
    #3 reset = 1'b0;
    #1;
    n_cmp++;
    if ({done, busy, err, conv_count, mem_addr, mem_wen, mem_wdata, cvt_start, cvt_in} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got done=%b busy=%b err=%b cnt=%h addr=%h wen=%b wd=%h cs=%b ci=%h want all zero",
               done, busy, err, conv_count, mem_addr, mem_wen, mem_wdata, cvt_start, cvt_in);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    mem[4] = 8'h00; mem[5] = 8'h40;
    exp_cvt.push_back(16'h4000);
    exp_wr.push_back({8'h06, 8'h02}); exp_wr.push_back({8'h07, 8'h00});
    run_batch(8'h04, 4'd1, 100, 0, 1'b0, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    n_cmp++; if (n_st != 1) begin n_bad++; $display("FAIL single_starts: got %0d want 1", n_st); end
    n_cmp++; if (done_cyc != 10) begin n_bad++; $display("FAIL single_done_cycle: got %0d want 10", done_cyc); end
    n_cmp++; if (done_cyc - st_cyc != 7) begin n_bad++; $display("FAIL single_start_to_done: got %0d want 7", done_cyc - st_cyc); end
    n_cmp++; if (busy_cyc != 9) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 9", busy_cyc); end
    n_cmp++; if ({err, conv_count} !== {1'b0, 4'd1}) begin n_bad++; $display("FAIL single_status: got err=%b cnt=%0d want err=0 cnt=1", err, conv_count); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({done, busy, mem_wen} !== 3'b100) begin n_bad++; $display("FAIL single_done_held: got done/busy/wen=%b want 100", {done, busy, mem_wen}); end
    n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL single_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL single_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL single_write addr/data: got %h want %h", o16, e16); end
    end
  endtask

  task automatic test_back_to_back();
    mem[4]  = 8'h00; mem[5]  = 8'h3C;
    mem[8]  = 8'h00; mem[9]  = 8'hBC;
    mem[12] = 8'h80; mem[13] = 8'h7B;
    exp_cvt.push_back(16'h3C00); exp_cvt.push_back(16'hBC00); exp_cvt.push_back(16'h7B80);
    exp_wr.push_back({8'h06, 8'h01}); exp_wr.push_back({8'h07, 8'h00});
    exp_wr.push_back({8'h0A, 8'hFF}); exp_wr.push_back({8'h0B, 8'hFF});
    exp_wr.push_back({8'h0E, 8'hFF}); exp_wr.push_back({8'h0F, 8'h7F});
    run_batch(8'h04, 4'd3, 200, 0, 1'b0, 1'b1, done_cyc, st_cyc, n_st, busy_cyc);
    n_cmp++; if (n_st != 3) begin n_bad++; $display("FAIL batch_starts: got %0d want 3", n_st); end
    n_cmp++; if (done_cyc != 28) begin n_bad++; $display("FAIL batch_done_cycle: got %0d want 28", done_cyc); end
    n_cmp++; if (busy_cyc != 27) begin n_bad++; $display("FAIL batch_busy_cycles: got %0d want 27", busy_cyc); end
    n_cmp++; if ({err, conv_count} !== {1'b0, 4'd3}) begin n_bad++; $display("FAIL batch_status: got err=%b cnt=%0d want err=0 cnt=3", err, conv_count); end
    n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL batch_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL batch_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL batch_write addr/data: got %h want %h", o16, e16); end
    end
  endtask

  task automatic test_stale_done();
    man_en = 1'b1; man_done = 1'b1; man_out = 16'h1111;
    mem[8'h60] = 8'h00; mem[8'h61] = 8'h45;
    exp_cvt.push_back(16'h4500);
    exp_wr.push_back({8'h62, 8'h05}); exp_wr.push_back({8'h63, 8'h00});
    run_batch(8'h60, 4'd1, 100, 0, 1'b1, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    man_en = 1'b0;
    n_cmp++; if (done_cyc != 11) begin n_bad++; $display("FAIL stale_done_cycle: got %0d want 11", done_cyc); end
    n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL stale_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL stale_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL stale_write addr/data: got %h want %h", o16, e16); end
    end
  endtask

  task automatic test_timeout();
    mem[8'h80] = 8'h00; mem[8'h81] = 8'h3C;
    mem[8'h84] = 8'h00; mem[8'h85] = 8'h7E;
    exp_cvt.push_back(16'h3C00); exp_cvt.push_back(16'h7E00);
    exp_wr.push_back({8'h82, 8'h01}); exp_wr.push_back({8'h83, 8'h00});
    run_batch(8'h80, 4'd3, 1200, 0, 1'b0, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    n_cmp++; if (st_cyc != 12) begin n_bad++; $display("FAIL timeout_launch_cycle: got %0d want 12", st_cyc); end
    n_cmp++; if (done_cyc != 12 + int'(TIMEOUT) + 1) begin n_bad++; $display("FAIL timeout_done_cycle: got %0d want %0d", done_cyc, 12 + int'(TIMEOUT) + 1); end
    n_cmp++; if ({err, conv_count, busy} !== {1'b1, 4'd1, 1'b0}) begin n_bad++; $display("FAIL timeout_status: got err=%b cnt=%0d busy=%b want err=1 cnt=1 busy=0", err, conv_count, busy); end
    n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL timeout_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL timeout_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL timeout_write addr/data: got %h want %h", o16, e16); end
    end
  endtask

  task automatic test_zero_count();
    run_batch(8'h10, 4'd0, 20, 0, 1'b0, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    n_cmp++; if (done_cyc != 1) begin n_bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_cyc); end
    n_cmp++; if (n_st != 0 || obs_wr.size() != 0) begin n_bad++; $display("FAIL zero_no_access: got starts=%0d writes=%0d want 0/0", n_st, obs_wr.size()); end
    n_cmp++; if ({err, conv_count, busy} !== 6'b0) begin n_bad++; $display("FAIL zero_status: got err=%b cnt=%0d busy=%b want 0/0/0", err, conv_count, busy); end
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'h00; mem[8'hFF] = 8'hC5; mem[0] = 8'hAA; mem[1] = 8'hAA;
    exp_cvt.push_back(16'hC500);
    exp_wr.push_back({8'h00, 8'hFB}); exp_wr.push_back({8'h01, 8'hFF});
    run_batch(8'hFE, 4'd1, 100, 0, 1'b0, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    n_cmp++; if (done_cyc != 10) begin n_bad++; $display("FAIL wrap_done_cycle: got %0d want 10", done_cyc); end
    n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL wrap_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL wrap_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL wrap_write addr/data: got %h want %h", o16, e16); end
    end
  endtask

  task automatic test_reset_mid_batch();
    mem[8'h20] = 8'h00; mem[8'h21] = 8'h42;
    mem[8'h24] = 8'h00; mem[8'h25] = 8'h44;
    mem[8'h26] = 8'h5A; mem[8'h27] = 8'h5A;
    mem[8'h40] = 8'h00; mem[8'h41] = 8'hC5;
    exp_cvt.push_back(16'h4200); exp_cvt.push_back(16'h4400);
    exp_wr.push_back({8'h22, 8'h03}); exp_wr.push_back({8'h23, 8'h00});
    run_batch(8'h20, 4'd3, 100, 2, 1'b0, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    @(negedge clk);
    n_cmp++; if ({busy, conv_count} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL rstmid_before: got busy=%b cnt=%0d want 1/1", busy, conv_count); end
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({done, busy, err, conv_count, mem_addr, mem_wen, mem_wdata, cvt_start, cvt_in} !== '0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got done=%b busy=%b err=%b cnt=%h addr=%h wen=%b wd=%h cs=%b ci=%h want all zero",
               done, busy, err, conv_count, mem_addr, mem_wen, mem_wdata, cvt_start, cvt_in);
    end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL rstmid_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL rstmid_write addr/data: got %h want %h", o16, e16); end
    end
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if ({done, busy, mem_wen, cvt_start} !== 4'b0) begin n_bad++; $display("FAIL rstmid_idle_after: got done/busy/wen/cs=%b want 0000", {done, busy, mem_wen, cvt_start}); end
    exp_cvt.push_back(16'hC500);
    exp_wr.push_back({8'h42, 8'hFB}); exp_wr.push_back({8'h43, 8'hFF});
    run_batch(8'h40, 4'd1, 100, 0, 1'b0, 1'b0, done_cyc, st_cyc, n_st, busy_cyc);
    n_cmp++; if (done_cyc != 10 || conv_count !== 4'd1 || err !== 1'b0) begin n_bad++; $display("FAIL rstmid_rerun: got done_cyc=%0d cnt=%0d err=%b want 10/1/0", done_cyc, conv_count, err); end
    n_cmp++; if (obs_wr.size() != exp_wr.size()) begin n_bad++; $display("FAIL rstmid_wr_count: got %0d want %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_cvt.size() > 0) begin
      e16 = exp_cvt.pop_front();
      if (obs_cvt.size() > 0) o16 = obs_cvt.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL rerun_cvt_in: got %h want %h", o16, e16); end
    end
    while (exp_wr.size() > 0) begin
      e16 = exp_wr.pop_front();
      if (obs_wr.size() > 0) o16 = obs_wr.pop_front(); else o16 = 16'hxxxx;
      n_cmp++; if (o16 !== e16) begin n_bad++; $display("FAIL rerun_write addr/data: got %h want %h", o16, e16); end
    end
    n_cmp++; if ({mem[8'h26], mem[8'h27]} !== 16'h5A5A) begin n_bad++; $display("FAIL rstmid_no_partial: got %h want 5a5a", {mem[8'h26], mem[8'h27]}); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hAA;
    test_reset();
    test_single();
    test_back_to_back();
    test_stale_done();
    test_timeout();
    test_zero_count();
    test_wrap();
    test_reset_mid_batch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
